playfield_engine: RTL and testbench



---
 rtl/playfield_pkg.sv | 49 ++++
 rtl/playfield_pixel_port.sv | 54 +++++
 rtl/playfield_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_playfield_engine.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/playfield_pkg.sv
// playfield_pkg: shared types, constants and helpers for the playfield engine.
package playfield_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOCK,
    ST_SCAN,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam int CELL_EMPTY   = 0;
  localparam int ROW_MAX_BITS = 256;

  localparam logic [19:0] SCORE_0 = 20'd0;
  localparam logic [19:0] SCORE_1 = 20'd40;
  localparam logic [19:0] SCORE_2 = 20'd100;
  localparam logic [19:0] SCORE_3 = 20'd300;
  localparam logic [19:0] SCORE_4 = 20'd1200;

  function automatic logic [19:0] score_for(input logic [2:0] n);
    case (n)
      3'd0:    return SCORE_0;
      3'd1:    return SCORE_1;
      3'd2:    return SCORE_2;
      3'd3:    return SCORE_3;
      default: return SCORE_4;
    endcase
  endfunction

  // A row is full when every one of its cols cells has a nonzero colour.
  function automatic logic row_full(input logic [ROW_MAX_BITS-1:0] row,
                                    input int cols, input int cw);
    logic full;
    logic any;
    full = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < cols) begin
        any = 1'b0;
        for (int j = 0; j < 16; j++) begin
          if (j < cw) any = any | row[i*cw + j];
        end
        if (!any) full = 1'b0;
      end
    end
    return full;
  endfunction

endpackage

// File: rtl/playfield_pixel_port.sv
// playfield_pixel_port: maps the beam position to a grid cell and registers its colour.
module playfield_pixel_port
  import playfield_pkg::*;
#(
  parameter int COLS     = 10,
  parameter int ROWS     = 20,
  parameter int COLOR_W  = 3,
  parameter int CELL_PX  = 16,
  parameter int ORIGIN_X = 240,
  parameter int ORIGIN_Y = 80
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [9:0]                    draw_x,
  input  logic [9:0]                    draw_y,
  input  logic [ROWS*COLS*COLOR_W-1:0]  grid_flat,
  output logic                          pix_valid,
  output logic [COLOR_W-1:0]            pix_color
);
  localparam int PX_SH = $clog2(CELL_PX);

  logic               pix_valid_q, pix_valid_d;
  logic [COLOR_W-1:0] pix_color_q, pix_color_d;

  // Pixel to cell coordinates by shift, bounds test, then cell colour select.
  always_comb begin
    int dx;
    int dy;
    int col;
    int row;
    dx = int'(draw_x) - ORIGIN_X;
    dy = int'(draw_y) - ORIGIN_Y;
    col = dx >>> PX_SH;
    row = dy >>> PX_SH;
    pix_valid_d = (dx >= 0) && (dy >= 0) && (col < COLS) && (row < ROWS);
    pix_color_d = '0;
    if (pix_valid_d) pix_color_d = grid_flat[(row*COLS + col)*COLOR_W +: COLOR_W];
  end

  // Output register so the renderer sees a clean one-cycle-late colour.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid_q <= 1'b0;
      pix_color_q <= '0;
    end else begin
      pix_valid_q <= pix_valid_d;
      pix_color_q <= pix_color_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_color = pix_color_q;

endmodule

// File: rtl/playfield_engine.sv
// playfield_engine: settled-block grid, collision queries, lock merge and row clearing.
// Define PLAYFIELD_SCORE_EN to build in the score accumulator; otherwise score is tied to 0.
module playfield_engine
  import playfield_pkg::*;
#(
  parameter  int COLS     = 10,
  parameter  int ROWS     = 20,
  parameter  int COLOR_W  = 3,
  parameter  int CELL_PX  = 16,
  parameter  int ORIGIN_X = 240,
  parameter  int ORIGIN_Y = 80,
  localparam int XW       = $clog2(COLS),
  localparam int YW       = $clog2(ROWS)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 lock_valid,
  output logic                 lock_ready,
  input  logic [4*XW-1:0]      lock_x,
  input  logic [4*YW-1:0]      lock_y,
  input  logic [COLOR_W-1:0]   lock_color,
  input  logic                 chk_valid,
  input  logic [4*XW-1:0]      chk_x,
  input  logic [4*YW-1:0]      chk_y,
  output logic                 chk_done,
  output logic                 chk_hit,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  output logic                 pix_valid,
  output logic [COLOR_W-1:0]   pix_color,
  output logic                 busy,
  output logic [2:0]           lines_cleared,
  output logic [15:0]          lines_total,
  output logic                 top_out,
  output logic [19:0]          score
);
  localparam int ROW_W = COLS * COLOR_W;

  state_e               state_q, state_d;
  logic [ROW_W-1:0]     grid_q [ROWS];
  logic [ROW_W-1:0]     grid_d [ROWS];
  logic [ROWS*ROW_W-1:0] grid_flat;
  logic [YW-1:0]        r_q, r_d, r_above;
  logic [2:0]           clr_q, clr_d;
  logic [4*XW-1:0]      lx_q, lx_d;
  logic [4*YW-1:0]      ly_q, ly_d;
  logic [COLOR_W-1:0]   lc_q, lc_d, wr_color;
  logic [2:0]           lines_cleared_q, lines_cleared_d;
  logic [15:0]          lines_total_q, lines_total_d;
  logic                 top_out_q, top_out_d;
  logic                 chk_done_q, chk_done_d, chk_hit_q, chk_hit_d;
  logic                 row_r_full, row_above_full;
`ifdef PLAYFIELD_SCORE_EN
  logic [19:0]          score_q, score_d;
`endif

  assign r_above        = (r_q == '0) ? '0 : r_q - YW'(1);
  assign row_r_full     = row_full(ROW_MAX_BITS'(grid_q[r_q]), COLS, COLOR_W);
  assign row_above_full = (r_q != '0) && row_full(ROW_MAX_BITS'(grid_q[r_above]), COLS, COLOR_W);
  assign wr_color       = (lc_q == COLOR_W'(CELL_EMPTY)) ? COLOR_W'(1) : lc_q;

  // Sequencer; SHIFT re-tests row r as its new contents arrive so a stacked clear costs one cycle per row.
  always_comb begin
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
`ifdef PLAYFIELD_SCORE_EN
    logic [20:0]   score_sum;
    score_sum = '0;
    score_d   = score_q;
`endif
    cx              = '0;
    cy              = '0;
    state_d         = state_q;
    grid_d          = grid_q;
    r_d             = r_q;
    clr_d           = clr_q;
    lx_d            = lx_q;
    ly_d            = ly_q;
    lc_d            = lc_q;
    lines_cleared_d = lines_cleared_q;
    lines_total_d   = lines_total_q;
    top_out_d       = top_out_q;
    case (state_q)
      ST_IDLE: begin
        if (lock_valid) begin
          lx_d    = lock_x;
          ly_d    = lock_y;
          lc_d    = lock_color;
          state_d = ST_LOCK;
        end
      end
      ST_LOCK: begin
        for (int i = 0; i < 4; i++) begin
          cx = lx_q[i*XW +: XW];
          cy = ly_q[i*YW +: YW];
          if (int'(cx) < COLS && int'(cy) < ROWS)
            grid_d[cy][int'(cx)*COLOR_W +: COLOR_W] = wr_color;
        end
        r_d     = YW'(ROWS - 1);
        clr_d   = '0;
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (row_r_full)      state_d = ST_SHIFT;
        else if (r_q == '0)  state_d = ST_DONE;
        else                 r_d = r_q - YW'(1);
      end
      ST_SHIFT: begin
        for (int i = 1; i < ROWS; i++) begin
          if (i <= int'(r_q)) grid_d[i] = grid_q[i-1];
        end
        grid_d[0] = '0;
        clr_d     = clr_q + 3'd1;
        if (row_above_full) state_d = ST_SHIFT;
        else if (r_q == '0) state_d = ST_DONE;
        else begin
          r_d     = r_q - YW'(1);
          state_d = ST_SCAN;
        end
      end
      ST_DONE: begin
        lines_cleared_d = clr_q;
        lines_total_d   = lines_total_q + {13'd0, clr_q};
        top_out_d       = top_out_q | (|grid_q[0]);
`ifdef PLAYFIELD_SCORE_EN
        score_sum = {1'b0, score_q} + {1'b0, score_for(clr_q)};
        score_d   = score_sum[20] ? '1 : score_sum[19:0];
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Collision query against the settled grid; only answered while idle.
  always_comb begin
    logic [XW-1:0] qx;
    logic [YW-1:0] qy;
    logic          hit;
    qx  = '0;
    qy  = '0;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      qx = chk_x[i*XW +: XW];
      qy = chk_y[i*YW +: YW];
      if (int'(qx) >= COLS || int'(qy) >= ROWS) hit = 1'b1;
      else if (grid_q[qy][int'(qx)*COLOR_W +: COLOR_W] != '0) hit = 1'b1;
    end
    chk_done_d = chk_valid && (state_q == ST_IDLE);
    chk_hit_d  = chk_done_d && hit;
  end

  // State, grid and counter registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q         <= ST_IDLE;
      for (int i = 0; i < ROWS; i++) grid_q[i] <= '0;
      r_q             <= '0;
      clr_q           <= '0;
      lx_q            <= '0;
      ly_q            <= '0;
      lc_q            <= '0;
      lines_cleared_q <= '0;
      lines_total_q   <= '0;
      top_out_q       <= 1'b0;
      chk_done_q      <= 1'b0;
      chk_hit_q       <= 1'b0;
`ifdef PLAYFIELD_SCORE_EN
      score_q         <= '0;
`endif
    end else begin
      state_q         <= state_d;
      grid_q          <= grid_d;
      r_q             <= r_d;
      clr_q           <= clr_d;
      lx_q            <= lx_d;
      ly_q            <= ly_d;
      lc_q            <= lc_d;
      lines_cleared_q <= lines_cleared_d;
      lines_total_q   <= lines_total_d;
      top_out_q       <= top_out_d;
      chk_done_q      <= chk_done_d;
      chk_hit_q       <= chk_hit_d;
`ifdef PLAYFIELD_SCORE_EN
      score_q         <= score_d;
`endif
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_flat
    assign grid_flat[gi*ROW_W +: ROW_W] = grid_q[gi];
  end

  playfield_pixel_port #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .COLOR_W  (COLOR_W),
    .CELL_PX  (CELL_PX),
    .ORIGIN_X (ORIGIN_X),
    .ORIGIN_Y (ORIGIN_Y)
  ) u_pixel_port (
    .clk       (Clk),
    .reset     (Reset),
    .draw_x    (DrawX),
    .draw_y    (DrawY),
    .grid_flat (grid_flat),
    .pix_valid (pix_valid),
    .pix_color (pix_color)
  );

  assign lock_ready    = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign chk_done      = chk_done_q;
  assign chk_hit       = chk_hit_q;
  assign lines_cleared = lines_cleared_q;
  assign lines_total   = lines_total_q;
  assign top_out       = top_out_q;
`ifdef PLAYFIELD_SCORE_EN
  assign score = score_q;
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_playfield_engine.sv
// tb_playfield_engine: scoreboard-driven bench for playfield_engine (default 10x20 field).
module tb_playfield_engine;
  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int CYC_N0 = 1 + ROWS + 0 + 1;
  localparam int CYC_N1 = 1 + ROWS + 1 + 1;
  localparam int CYC_N4 = 1 + ROWS + 4 + 1;
`ifdef PLAYFIELD_SCORE_EN
  localparam logic [19:0] EXP_SCORE_1 = 20'd40;
  localparam logic [19:0] EXP_SCORE_4 = 20'd1200;
`else
  localparam logic [19:0] EXP_SCORE_1 = 20'd0;
  localparam logic [19:0] EXP_SCORE_4 = 20'd0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        lock_valid = 1'b0;
  logic        lock_ready;
  logic [15:0] lock_x = '0;
  logic [19:0] lock_y = '0;
  logic [2:0]  lock_color = '0;
  logic        chk_valid = 1'b0;
  logic [15:0] chk_x = '0;
  logic [19:0] chk_y = '0;
  logic        chk_done, chk_hit;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        pix_valid;
  logic [2:0]  pix_color;
  logic        busy;
  logic [2:0]  lines_cleared;
  logic [15:0] lines_total;
  logic        top_out;
  logic [19:0] score;

  typedef struct { int lines; int cycles; } lock_exp_t;
  typedef struct { logic valid; logic [2:0] color; } pix_exp_t;

  lock_exp_t lock_sb[$];
  pix_exp_t  pix_sb[$];
  logic      chk_sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 Clk = ~Clk;

  playfield_engine #(
    .COLS(COLS), .ROWS(ROWS), .COLOR_W(3), .CELL_PX(16), .ORIGIN_X(240), .ORIGIN_Y(80)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .lock_valid(lock_valid), .lock_ready(lock_ready),
    .lock_x(lock_x), .lock_y(lock_y), .lock_color(lock_color),
    .chk_valid(chk_valid), .chk_x(chk_x), .chk_y(chk_y),
    .chk_done(chk_done), .chk_hit(chk_hit),
    .DrawX(DrawX), .DrawY(DrawY),
    .pix_valid(pix_valid), .pix_color(pix_color),
    .busy(busy), .lines_cleared(lines_cleared), .lines_total(lines_total),
    .top_out(top_out), .score(score)
  );

  function automatic logic [15:0] px4(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  function automatic logic [19:0] py4(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic int cell_px(input int col);
    return 240 + 16*col + 8;
  endfunction

  function automatic int cell_py(input int row);
    return 80 + 16*row + 8;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    lock_valid = 1'b0;
    chk_valid  = 1'b0;
    DrawX      = '0;
    DrawY      = '0;
    Reset      = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    lock_sb.delete();
    pix_sb.delete();
    chk_sb.delete();
  endtask

  // Drives one lock and waits (bounded) for the engine to go idle again.
  task automatic run_lock(input logic [15:0] xs, input logic [19:0] ys, input logic [2:0] col,
                          output int cycles);
    lock_x     = xs;
    lock_y     = ys;
    lock_color = col;
    lock_valid = 1'b1;
    tick();
    lock_valid = 1'b0;
    cycles = 0;
    while (busy && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  task automatic sample_pix(input int x, input int y, output logic v, output logic [2:0] c);
    DrawX = 10'(x);
    DrawY = 10'(y);
    tick();
    v = pix_valid;
    c = pix_color;
  endtask

  task automatic prefill_row19();
    int cyc;
    run_lock(px4(4, 5, 6, 7), py4(19, 19, 19, 19), 3'd5, cyc);
    run_lock(px4(8, 9, 8, 9), py4(19, 19, 19, 19), 3'd6, cyc);
  endtask

  task automatic prefill_stack();
    int cyc;
    for (int c = 1; c < COLS; c++)
      run_lock(px4(c, c, c, c), py4(16, 17, 18, 19), 3'((c % 7) + 1), cyc);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({lock_ready, busy, chk_done, chk_hit} !== 4'b1000)
      $display("[TB] FAIL reset_handshake: got %b expected 1000", {lock_ready, busy, chk_done, chk_hit});
    else n_pass++;
    n_checks++;
    if ({pix_valid, pix_color} !== 4'b0000)
      $display("[TB] FAIL reset_pixel: got %b expected 0000", {pix_valid, pix_color});
    else n_pass++;
    n_checks++;
    if ({lines_cleared, lines_total, top_out, score} !== 40'd0)
      $display("[TB] FAIL reset_counters: got lc=%0d lt=%0d to=%b sc=%0d expected all 0",
               lines_cleared, lines_total, top_out, score);
    else n_pass++;
  endtask

  task automatic test_lock_no_clear();
    int cyc;
    int pc[4] = '{0, 3, 4, 0};
    int pr[4] = '{19, 19, 19, 18};
    logic [2:0] pcol[4] = '{3'd2, 3'd2, 3'd0, 3'd0};
    lock_exp_t le;
    pix_exp_t pe;
    logic v;
    logic [2:0] c;
    apply_reset();
    le.lines = 0; le.cycles = CYC_N0;
    lock_sb.push_back(le);
    run_lock(px4(0, 1, 2, 3), py4(19, 19, 19, 19), 3'd2, cyc);
    le = lock_sb.pop_front();
    n_checks++;
    if (cyc !== le.cycles) $display("[TB] FAIL noclear_cycles: got %0d expected %0d", cyc, le.cycles);
    else n_pass++;
    n_checks++;
    if (int'(lines_cleared) !== le.lines)
      $display("[TB] FAIL noclear_lines: got %0d expected %0d", lines_cleared, le.lines);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      pe.valid = 1'b1; pe.color = pcol[k];
      pix_sb.push_back(pe);
      sample_pix(cell_px(pc[k]), cell_py(pr[k]), v, c);
      pe = pix_sb.pop_front();
      n_checks++;
      if ({v, c} !== {pe.valid, pe.color})
        $display("[TB] FAIL noclear_pix(%0d,%0d): got v=%b c=%0d expected v=%b c=%0d",
                 pc[k], pr[k], v, c, pe.valid, pe.color);
      else n_pass++;
    end
  endtask

  task automatic test_single_clear();
    int cyc;
    lock_exp_t le;
    pix_exp_t pe;
    logic v;
    logic [2:0] c;
    apply_reset();
    prefill_row19();
    le.lines = 1; le.cycles = CYC_N1;
    lock_sb.push_back(le);
    run_lock(px4(0, 1, 2, 3), py4(19, 19, 19, 19), 3'd3, cyc);
    le = lock_sb.pop_front();
    n_checks++;
    if (cyc !== le.cycles) $display("[TB] FAIL single_cycles: got %0d expected %0d", cyc, le.cycles);
    else n_pass++;
    n_checks++;
    if (int'(lines_cleared) !== le.lines)
      $display("[TB] FAIL single_lines: got %0d expected %0d", lines_cleared, le.lines);
    else n_pass++;
    n_checks++;
    if (lines_total !== 16'd1) $display("[TB] FAIL single_total: got %0d expected 1", lines_total);
    else n_pass++;
    n_checks++;
    if (score !== EXP_SCORE_1) $display("[TB] FAIL single_score: got %0d expected %0d", score, EXP_SCORE_1);
    else n_pass++;
    for (int k = 0; k < COLS; k++) begin
      pe.valid = 1'b1; pe.color = 3'd0;
      pix_sb.push_back(pe);
      sample_pix(cell_px(k), cell_py(19), v, c);
      pe = pix_sb.pop_front();
      n_checks++;
      if ({v, c} !== {pe.valid, pe.color})
        $display("[TB] FAIL single_row19(%0d): got v=%b c=%0d expected v=%b c=%0d", k, v, c, pe.valid, pe.color);
      else n_pass++;
    end
  endtask

  task automatic test_tetris();
    int cyc;
    lock_exp_t le;
    pix_exp_t pe;
    logic v;
    logic [2:0] c;
    apply_reset();
    prefill_stack();
    le.lines = 4; le.cycles = CYC_N4;
    lock_sb.push_back(le);
    run_lock(px4(0, 0, 0, 0), py4(16, 17, 18, 19), 3'd4, cyc);
    le = lock_sb.pop_front();
    n_checks++;
    if (cyc !== le.cycles) $display("[TB] FAIL tetris_cycles: got %0d expected %0d", cyc, le.cycles);
    else n_pass++;
    n_checks++;
    if (int'(lines_cleared) !== le.lines)
      $display("[TB] FAIL tetris_lines: got %0d expected %0d", lines_cleared, le.lines);
    else n_pass++;
    n_checks++;
    if (lines_total !== 16'd4) $display("[TB] FAIL tetris_total: got %0d expected 4", lines_total);
    else n_pass++;
    n_checks++;
    if (score !== EXP_SCORE_4) $display("[TB] FAIL tetris_score: got %0d expected %0d", score, EXP_SCORE_4);
    else n_pass++;
    for (int r = 16; r < ROWS; r++) begin
      for (int k = 0; k < COLS; k += 9) begin
        pe.valid = 1'b1; pe.color = 3'd0;
        pix_sb.push_back(pe);
        sample_pix(cell_px(k), cell_py(r), v, c);
        pe = pix_sb.pop_front();
        n_checks++;
        if ({v, c} !== {pe.valid, pe.color})
          $display("[TB] FAIL tetris_pix(%0d,%0d): got v=%b c=%0d expected v=%b c=%0d", k, r, v, c, pe.valid, pe.color);
        else n_pass++;
      end
    end
  endtask

  task automatic test_pixel_bounds();
    int cyc;
    int bx[5] = '{239, 400, 240, 399, 399};
    int by[5] = '{100, 100,  79, 399, 400};
    logic       bv[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0] bc[5] = '{3'd0, 3'd0, 3'd0, 3'd7, 3'd0};
    pix_exp_t pe;
    logic v;
    logic [2:0] c;
    apply_reset();
    run_lock(px4(9, 9, 9, 9), py4(19, 19, 19, 19), 3'd7, cyc);
    for (int k = 0; k < 5; k++) begin
      pe.valid = bv[k]; pe.color = bc[k];
      pix_sb.push_back(pe);
      sample_pix(bx[k], by[k], v, c);
      pe = pix_sb.pop_front();
      n_checks++;
      if ({v, c} !== {pe.valid, pe.color})
        $display("[TB] FAIL bounds_pix(%0d,%0d): got v=%b c=%0d expected v=%b c=%0d", bx[k], by[k], v, c, pe.valid, pe.color);
      else n_pass++;
    end
  endtask

  task automatic test_collision();
    int cyc;
    logic [15:0] qx[6];
    logic [19:0] qy[6];
    logic        qh[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        e;
    apply_reset();
    run_lock(px4(4, 5, 6, 7), py4(10, 10, 10, 10), 3'd3, cyc);
    qx[0] = px4(10, 0, 0, 0); qy[0] = py4(0, 0, 1, 2);
    qx[1] = px4(0, 1, 2, 3);  qy[1] = py4(0, 0, 0, 0);
    qx[2] = px4(9, 8, 9, 0);  qy[2] = py4(19, 19, 18, 0);
    qx[3] = px4(1, 1, 1, 1);  qy[3] = py4(17, 18, 19, 20);
    qx[4] = px4(5, 5, 5, 5);  qy[4] = py4(8, 9, 10, 11);
    qx[5] = px4(5, 5, 3, 8);  qy[5] = py4(9, 11, 10, 10);
    for (int k = 0; k < 6; k++) begin
      chk_x = qx[k]; chk_y = qy[k]; chk_valid = 1'b1;
      chk_sb.push_back(qh[k]);
      tick();
      chk_valid = 1'b0;
      e = chk_sb.pop_front();
      n_checks++;
      if ({chk_done, chk_hit} !== {1'b1, e})
        $display("[TB] FAIL query%0d: got done=%b hit=%b expected done=1 hit=%b", k, chk_done, chk_hit, e);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (chk_done !== 1'b0) $display("[TB] FAIL query_pulse: got done=%b expected 0", chk_done);
    else n_pass++;
  endtask

  task automatic test_busy_query();
    int cyc;
    logic e;
    apply_reset();
    lock_x = px4(5, 6, 7, 8); lock_y = py4(10, 10, 10, 10); lock_color = 3'd2; lock_valid = 1'b1;
    chk_x = px4(5, 5, 5, 5); chk_y = py4(10, 10, 10, 10); chk_valid = 1'b1;
    chk_sb.push_back(1'b0);
    tick();
    lock_valid = 1'b0;
    e = chk_sb.pop_front();
    n_checks++;
    if ({chk_done, chk_hit} !== {1'b1, e})
      $display("[TB] FAIL prelock_query: got done=%b hit=%b expected done=1 hit=%b", chk_done, chk_hit, e);
    else n_pass++;
    chk_x = px4(0, 1, 2, 3); chk_y = py4(0, 0, 0, 0);
    tick();
    cyc = 1;
    n_checks++;
    if (chk_done !== 1'b0) $display("[TB] FAIL busy_query_dropped: got done=%b expected 0", chk_done);
    else n_pass++;
    chk_valid = 1'b0;
    while (busy && cyc < 100) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc !== CYC_N0) $display("[TB] FAIL busy_cycles: got %0d expected %0d", cyc, CYC_N0);
    else n_pass++;
    chk_x = px4(5, 5, 5, 5); chk_y = py4(10, 10, 10, 10); chk_valid = 1'b1;
    chk_sb.push_back(1'b1);
    tick();
    chk_valid = 1'b0;
    e = chk_sb.pop_front();
    n_checks++;
    if ({chk_done, chk_hit} !== {1'b1, e})
      $display("[TB] FAIL postlock_query: got done=%b hit=%b expected done=1 hit=%b", chk_done, chk_hit, e);
    else n_pass++;
  endtask

  task automatic test_top_out();
    int cyc;
    pix_exp_t pe;
    logic v;
    logic [2:0] c;
    apply_reset();
    run_lock(px4(0, 1, 0, 12), py4(0, 0, 1, 3), 3'd0, cyc);
    n_checks++;
    if (top_out !== 1'b1) $display("[TB] FAIL topout_set: got %b expected 1", top_out);
    else n_pass++;
    pe.valid = 1'b1; pe.color = 3'd1;
    pix_sb.push_back(pe);
    sample_pix(cell_px(0), cell_py(0), v, c);
    pe = pix_sb.pop_front();
    n_checks++;
    if ({v, c} !== {pe.valid, pe.color})
      $display("[TB] FAIL color0_written_as1: got v=%b c=%0d expected v=%b c=%0d", v, c, pe.valid, pe.color);
    else n_pass++;
    pe.valid = 1'b1; pe.color = 3'd0;
    pix_sb.push_back(pe);
    sample_pix(cell_px(1), cell_py(1), v, c);
    pe = pix_sb.pop_front();
    n_checks++;
    if ({v, c} !== {pe.valid, pe.color})
      $display("[TB] FAIL topout_untouched: got v=%b c=%0d expected v=%b c=%0d", v, c, pe.valid, pe.color);
    else n_pass++;
    run_lock(px4(5, 6, 5, 6), py4(15, 15, 16, 16), 3'd5, cyc);
    n_checks++;
    if (top_out !== 1'b1) $display("[TB] FAIL topout_sticky: got %b expected 1", top_out);
    else n_pass++;
    apply_reset();
    n_checks++;
    if (top_out !== 1'b0) $display("[TB] FAIL topout_reset: got %b expected 0", top_out);
    else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    int cyc;
    pix_exp_t pe;
    logic v;
    logic [2:0] c;
    apply_reset();
    prefill_row19();
    run_lock(px4(0, 1, 2, 3), py4(19, 19, 19, 19), 3'd3, cyc);
    n_checks++;
    if (lines_total !== 16'd1) $display("[TB] FAIL midshift_pre_total: got %0d expected 1", lines_total);
    else n_pass++;
    prefill_stack();
    lock_x = px4(0, 0, 0, 0); lock_y = py4(16, 17, 18, 19); lock_color = 3'd4; lock_valid = 1'b1;
    tick();
    lock_valid = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_checks++;
    if ({lock_ready, busy} !== 2'b10)
      $display("[TB] FAIL midshift_handshake: got %b expected 10", {lock_ready, busy});
    else n_pass++;
    n_checks++;
    if ({lines_cleared, lines_total, top_out, score} !== 40'd0)
      $display("[TB] FAIL midshift_counters: got lc=%0d lt=%0d to=%b sc=%0d expected all 0",
               lines_cleared, lines_total, top_out, score);
    else n_pass++;
    for (int r = 15; r < ROWS; r++) begin
      pe.valid = 1'b1; pe.color = 3'd0;
      pix_sb.push_back(pe);
      sample_pix(cell_px(5), cell_py(r), v, c);
      pe = pix_sb.pop_front();
      n_checks++;
      if ({v, c} !== {pe.valid, pe.color})
        $display("[TB] FAIL midshift_grid(5,%0d): got v=%b c=%0d expected v=%b c=%0d", r, v, c, pe.valid, pe.color);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_lock_no_clear();
    test_single_clear();
    test_tetris();
    test_pixel_bounds();
    test_collision();
    test_busy_query();
    test_top_out();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
